model_vector_fixed_summation: RTL and testbench
===============================================

# model_vector_fixed_summation

Streaming reduction stage that sits directly downstream of the vector fixed-point divider. It accepts one signed fixed-point element per `DATA_IN_ENABLE` pulse (wired to the divider's `DATA_OUT_ENABLE`/`DATA_OUT`) and accumulates `SIZE_IN` elements with saturation. It then presents the sum on `DATA_OUT` with a one-cycle `READY`/`DATA_OUT_ENABLE` pulse. `OVERFLOW` is a sticky per-run flag.

## Interface
- `DATA_SIZE`, 64, element and result width, signed two's complement.
- `CONTROL_SIZE`, 64, width of the element index counter.
- `CLK`  in  1  single clock; all logic on rising edge.
- `RST`  in  1  reset, synchronous, active-high.
- `START`  in  1  begin a run; sampled only in STARTER_STATE.
- `READY`  out  1  one-cycle pulse when the sum is valid.
- `DATA_IN_ENABLE`  in  1  element strobe; sampled only in INPUT_STATE.
- `DATA_OUT_ENABLE`  out  1  one-cycle pulse, coincident with `READY`.
- `OVERFLOW`  out  1  sticky saturation flag for the current run.
- `SIZE_IN`  in  `DATA_SIZE`  element count; captured on accepted `START`.
- `DATA_IN`  in  `DATA_SIZE`  element value, valid with `DATA_IN_ENABLE`.
- `DATA_OUT`  out  `DATA_SIZE`  saturated sum; held until the next result.

## Operation
- FSM states: STARTER_STATE=0, INPUT_STATE=1, ENDER_STATE=2. Encoding 3 is illegal and returns to STARTER_STATE.
- Internal registers:
  - `size_int`: captured `SIZE_IN`.
  - `index_loop`: `CONTROL_SIZE` bits.
  - `acc`: `DATA_SIZE` bits, signed.
- STARTER_STATE:
  - `READY`<=0, `DATA_OUT_ENABLE`<=0.
  - On `START`=1: `acc`<=0, `index_loop`<=0, `OVERFLOW`<=0, `size_int`<=`SIZE_IN`.
  - Go to ENDER_STATE if `SIZE_IN`==0, else INPUT_STATE.
- INPUT_STATE, on `DATA_IN_ENABLE`=1:
  - `acc`<=sat(`acc`+`DATA_IN`).
  - If `index_loop`==`size_int`-1, go to ENDER_STATE; else `index_loop`++.
  - Idle cycles (strobe low) leave all state unchanged.
- ENDER_STATE: `DATA_OUT`<=`acc`, `READY`<=1, `DATA_OUT_ENABLE`<=1, go to STARTER_STATE.
- Arithmetic:
  - Sum formed at `DATA_SIZE`+1 bits, signed.
  - Above 2^(DATA_SIZE-1)-1: clamp to max, set `OVERFLOW`.
  - Below -2^(DATA_SIZE-1): clamp to min, set `OVERFLOW`.
  - Later elements add to the clamped value.
  - `OVERFLOW` holds until the next accepted `START` or `RST`.
- Ignored inputs:
  - `START` outside STARTER_STATE.
  - `DATA_IN_ENABLE` outside INPUT_STATE.
  - `SIZE_IN` changes after capture.

## Timing
- Reset values: `READY`=0, `DATA_OUT_ENABLE`=0, `OVERFLOW`=0, `DATA_OUT`=0, `acc`=0, `index_loop`=0, state STARTER_STATE.
- `RST` in any state, including mid-run, wins over all other inputs at that edge. The partial sum is discarded.
- Latency, counted from the edge that samples the last `DATA_IN_ENABLE`:
  - FSM is in ENDER_STATE after that edge.
  - `READY`/`DATA_OUT_ENABLE`/`DATA_OUT` are valid after the next edge.
  - `READY`/`DATA_OUT_ENABLE` deassert after the edge following that.
- `SIZE_IN`=0: edge sampling `START` goes to ENDER_STATE; the next edge outputs `DATA_OUT`=0 with a `READY` pulse.
- Back-to-back runs:
  - `START` can be accepted on the cycle `READY` is high; the FSM is in STARTER_STATE then.
  - The next `DATA_IN_ENABLE` can be accepted one cycle later.
- Throughput: one element per cycle with `DATA_IN_ENABLE` held high. No backpressure; the upstream divider's pacing is always absorbed.
- `OVERFLOW` updates on the same edge as the saturating accumulate.

## Test plan
- Basic sum: `DATA_SIZE`=16, `SIZE_IN`=4, elements 1,2,3,4 on consecutive cycles.
  - Required: `DATA_OUT`=10, `READY`=`DATA_OUT_ENABLE`=1 for exactly one cycle, two edges after the 4th strobe; `OVERFLOW`=0.
- Positive saturation: `SIZE_IN`=3, elements 0x7000, 0x2000, 0xF000 (-4096).
  - Required: `DATA_OUT`=0x6FFF (clamp to 0x7FFF, then -0x1000); `OVERFLOW`=1.
- Negative saturation, then a new run:
  - First run: `SIZE_IN`=2, elements 0x8000, 0xFFFF. Required: `DATA_OUT`=0x8000, `OVERFLOW`=1.
  - Next run: `START` with `SIZE_IN`=1, element 5. Required: `OVERFLOW` clears on `START`; `DATA_OUT`=5.
- Gapped strobes and ignored inputs:
  - Stimulus: `SIZE_IN`=3, elements 7,-2,9 with 0/3/1 idle cycles between them; `START` pulsed mid-run; `SIZE_IN` changed to 1 mid-run.
  - Required: single `READY`, `DATA_OUT`=14.
- `SIZE_IN`=0:
  - Required: `DATA_OUT`=0 and a `READY` pulse on the second edge after `START`.
  - Strobes presented during that window are ignored.
- Reset mid-run:
  - Stimulus: `SIZE_IN`=4, assert `RST` after 2 elements (values 100, 200).
  - Required: all outputs 0, no `READY`.
  - Follow-up run: `SIZE_IN`=2, elements 1,1. Required: `DATA_OUT`=2.

Source files
------------

// File: rtl/model_vector_fixed_summation.sv
// Streaming saturating summation stage for the vector fixed-point divider output.
// A run is started with START. It then accumulates SIZE_IN signed elements, one
// per DATA_IN_ENABLE strobe, and presents the clamped sum with a one-cycle
// READY/DATA_OUT_ENABLE pulse.
//
// Handshake: DATA_IN_ENABLE is a valid-only strobe with no backpressure. It is
// consumed on every rising edge where the FSM is in INPUT_STATE and is ignored
// in every other state. READY and DATA_OUT_ENABLE are the same one-cycle valid
// pulse, and DATA_OUT holds its value until the next result.
module model_vector_fixed_summation #(
    parameter int DATA_SIZE    = 64,
    parameter int CONTROL_SIZE = 64
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    output logic                 READY,
    input  logic                 DATA_IN_ENABLE,
    output logic                 DATA_OUT_ENABLE,
    output logic                 OVERFLOW,
    input  logic [DATA_SIZE-1:0] SIZE_IN,
    input  logic [DATA_SIZE-1:0] DATA_IN,
    output logic [DATA_SIZE-1:0] DATA_OUT,
    output logic [1:0]           state_dbg
);

    typedef enum logic [1:0] {
        STARTER_STATE = 2'd0,
        INPUT_STATE   = 2'd1,
        ENDER_STATE   = 2'd2
    } state_t;

    localparam logic [DATA_SIZE-1:0] SAT_MAX = {1'b0, {(DATA_SIZE-1){1'b1}}};
    localparam logic [DATA_SIZE-1:0] SAT_MIN = {1'b1, {(DATA_SIZE-1){1'b0}}};

    state_t                  state, state_n;
    logic [DATA_SIZE-1:0]    size_int, size_n;
    logic [CONTROL_SIZE-1:0] index_loop, index_n;
    logic [DATA_SIZE-1:0]    acc, acc_n;
    logic                    overflow_q, overflow_n;
    logic                    ready_q, ready_n;
    logic [DATA_SIZE-1:0]    data_out_q, data_out_n;

    logic [DATA_SIZE:0]      sum_wide;
    logic                    sat_pos, sat_neg;
    logic [DATA_SIZE-1:0]    sum_sat;
    logic [DATA_SIZE-1:0]    index_ext;

    // Sign-extended sum one bit wider than the operands. When the two top bits
    // disagree the true sum does not fit, and the direction tells which rail to clamp to.
    assign sum_wide  = {acc[DATA_SIZE-1], acc} + {DATA_IN[DATA_SIZE-1], DATA_IN};
    assign sat_pos   = ~sum_wide[DATA_SIZE] &  sum_wide[DATA_SIZE-1];
    assign sat_neg   =  sum_wide[DATA_SIZE] & ~sum_wide[DATA_SIZE-1];
    assign sum_sat   = sat_pos ? SAT_MAX : (sat_neg ? SAT_MIN : sum_wide[DATA_SIZE-1:0]);
    assign index_ext = DATA_SIZE'(index_loop);

    assign READY           = ready_q;
    assign DATA_OUT_ENABLE = ready_q;
    assign OVERFLOW        = overflow_q;
    assign DATA_OUT        = data_out_q;
    assign state_dbg       = state;

    // Next-state and next-register values; every value holds unless a state acts on it
    always_comb begin
        state_n    = state;
        size_n     = size_int;
        index_n    = index_loop;
        acc_n      = acc;
        overflow_n = overflow_q;
        ready_n    = 1'b0;
        data_out_n = data_out_q;
        case (state)
            STARTER_STATE: begin
                if (START) begin
                    acc_n      = '0;
                    index_n    = '0;
                    overflow_n = 1'b0;
                    size_n     = SIZE_IN;
                    state_n    = (SIZE_IN == '0) ? ENDER_STATE : INPUT_STATE;
                end
            end
            INPUT_STATE: begin
                if (DATA_IN_ENABLE) begin
                    acc_n = sum_sat;
                    if (sat_pos || sat_neg) begin
                        overflow_n = 1'b1;
                    end
                    if (index_ext == size_int - DATA_SIZE'(1)) begin
                        state_n = ENDER_STATE;
                    end else begin
                        index_n = index_loop + CONTROL_SIZE'(1);
                    end
                end
            end
            ENDER_STATE: begin
                data_out_n = acc;
                ready_n    = 1'b1;
                state_n    = STARTER_STATE;
            end
            default: begin
                state_n = STARTER_STATE;
            end
        endcase
    end

    // State and datapath registers; reset takes priority over every other input
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= STARTER_STATE;
            size_int   <= '0;
            index_loop <= '0;
            acc        <= '0;
            overflow_q <= 1'b0;
            ready_q    <= 1'b0;
            data_out_q <= '0;
        end else begin
            state      <= state_n;
            size_int   <= size_n;
            index_loop <= index_n;
            acc        <= acc_n;
            overflow_q <= overflow_n;
            ready_q    <= ready_n;
            data_out_q <= data_out_n;
        end
    end

endmodule

// File: tb/tb_model_vector_fixed_summation.sv
// Self-checking bench for model_vector_fixed_summation at DATA_SIZE=16.
module tb_model_vector_fixed_summation;

    localparam int W  = 16;
    localparam int CW = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         die;
    logic [W-1:0] size_in;
    logic [W-1:0] data_in;
    logic         ready;
    logic         doe;
    logic         ovf;
    logic [W-1:0] dout;
    logic [1:0]   state_dbg;

    int tests_run    = 0;
    int tests_failed = 0;

    // Stimulus for one run: element values and idle cycles before each element
    logic [W-1:0] elem_q[$];
    int           gap_q[$];

    // Observations from the last run
    int           obs_lat;
    int           obs_cnt;
    logic [W-1:0] obs_dout;
    logic         obs_ovf;
    logic         obs_ovf_start;
    logic [1:0]   obs_state_last;
    logic         obs_doe_ok;

    model_vector_fixed_summation #(.DATA_SIZE(W), .CONTROL_SIZE(CW)) dut (
        .CLK             (clk),
        .RST             (rst),
        .START           (start),
        .READY           (ready),
        .DATA_IN_ENABLE  (die),
        .DATA_OUT_ENABLE (doe),
        .OVERFLOW        (ovf),
        .SIZE_IN         (size_in),
        .DATA_IN         (data_in),
        .DATA_OUT        (dout),
        .state_dbg       (state_dbg)
    );

    always #5 clk = ~clk;

    // Reference: sum with clamping after each element, in plain integer arithmetic
    function automatic void model_sum(output logic [W-1:0] s, output logic o);
        int acc;
        acc = 0;
        o   = 1'b0;
        foreach (elem_q[i]) begin
            acc = acc + int'($signed(elem_q[i]));
            if (acc > 32767) begin
                acc = 32767;
                o   = 1'b1;
            end else if (acc < -32768) begin
                acc = -32768;
                o   = 1'b1;
            end
        end
        s = acc[W-1:0];
    endfunction

    // Drive one run from elem_q/gap_q and observe the result window (bounded)
    task automatic run_vector(input logic [W-1:0] size, input bit disturb, input bit strobe_window);
        start   = 1'b1;
        size_in = size;
        @(posedge clk); #1;
        start          = 1'b0;
        obs_ovf_start  = ovf;
        obs_state_last = state_dbg;
        for (int i = 0; i < elem_q.size(); i++) begin
            for (int g = 0; g < gap_q[i]; g++) begin
                if (disturb) begin
                    start   = 1'b1;
                    size_in = 16'd1;
                end
                @(posedge clk); #1;
                start = 1'b0;
            end
            die     = 1'b1;
            data_in = elem_q[i];
            @(posedge clk); #1;
            die            = 1'b0;
            data_in        = W'($urandom);
            obs_state_last = state_dbg;
        end
        obs_lat    = -1;
        obs_cnt    = 0;
        obs_doe_ok = 1'b1;
        obs_dout   = 'x;
        obs_ovf    = 1'bx;
        for (int k = 1; k <= 6; k++) begin
            if (strobe_window) begin
                die     = 1'b1;
                data_in = W'($urandom);
            end
            @(posedge clk); #1;
            if (ready === 1'b1) begin
                if (obs_lat < 0) begin
                    obs_lat  = k;
                    obs_dout = dout;
                    obs_ovf  = ovf;
                end
                obs_cnt++;
            end
            if (doe !== ready) obs_doe_ok = 1'b0;
        end
        die = 1'b0;
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        start   = 1'b0;
        die     = 1'b0;
        size_in = '0;
        data_in = '0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if ({ready, doe, ovf, dout, state_dbg} !== {3'b000, 16'h0000, 2'd0}) begin
            tests_failed++;
            $display("FAIL reset_outputs: got ready=%b doe=%b ovf=%b dout=%h st=%0d required all 0",
                     ready, doe, ovf, dout, state_dbg);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        elem_q = '{16'd1, 16'd2, 16'd3, 16'd4};
        gap_q  = '{0, 0, 0, 0};
        run_vector(16'd4, 1'b0, 1'b0);
        tests_run++;
        if (obs_state_last !== 2'd2) begin
            tests_failed++;
            $display("FAIL basic_ender_state: got %0d required 2", obs_state_last);
        end
        tests_run++;
        if (obs_lat !== 1) begin
            tests_failed++;
            $display("FAIL basic_latency: got %0d required 1", obs_lat);
        end
        tests_run++;
        if (obs_cnt !== 1 || obs_doe_ok !== 1'b1) begin
            tests_failed++;
            $display("FAIL basic_pulse: got %0d ready cycles doe_ok=%b required 1 and 1", obs_cnt, obs_doe_ok);
        end
        tests_run++;
        if (obs_dout !== 16'd10) begin
            tests_failed++;
            $display("FAIL basic_dout: got %h required %h", obs_dout, 16'd10);
        end
        tests_run++;
        if (obs_ovf !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_overflow: got %b required 0", obs_ovf);
        end
    endtask

    task automatic test_pos_saturation();
        elem_q = '{16'h7000, 16'h2000, 16'hF000};
        gap_q  = '{0, 0, 0};
        run_vector(16'd3, 1'b0, 1'b0);
        tests_run++;
        if (obs_dout !== 16'h6FFF) begin
            tests_failed++;
            $display("FAIL pos_sat_dout: got %h required 6fff", obs_dout);
        end
        tests_run++;
        if (obs_ovf !== 1'b1 || ovf !== 1'b1) begin
            tests_failed++;
            $display("FAIL pos_sat_overflow: got %b (held %b) required 1", obs_ovf, ovf);
        end
    endtask

    task automatic test_neg_saturation();
        elem_q = '{16'h8000, 16'hFFFF};
        gap_q  = '{0, 0};
        run_vector(16'd2, 1'b0, 1'b0);
        tests_run++;
        if (obs_dout !== 16'h8000 || obs_ovf !== 1'b1) begin
            tests_failed++;
            $display("FAIL neg_sat: got dout=%h ovf=%b required 8000 and 1", obs_dout, obs_ovf);
        end
        elem_q = '{16'd5};
        gap_q  = '{0};
        run_vector(16'd1, 1'b0, 1'b0);
        tests_run++;
        if (obs_ovf_start !== 1'b0) begin
            tests_failed++;
            $display("FAIL neg_sat_ovf_clear: got %b required 0", obs_ovf_start);
        end
        tests_run++;
        if (obs_dout !== 16'd5 || obs_ovf !== 1'b0 || obs_lat !== 1) begin
            tests_failed++;
            $display("FAIL neg_sat_next_run: got dout=%h ovf=%b lat=%0d required 0005 0 1", obs_dout, obs_ovf, obs_lat);
        end
    endtask

    task automatic test_gapped_ignored();
        elem_q = '{16'd7, 16'hFFFE, 16'd9};
        gap_q  = '{0, 3, 1};
        run_vector(16'd3, 1'b1, 1'b0);
        tests_run++;
        if (obs_cnt !== 1 || obs_lat !== 1) begin
            tests_failed++;
            $display("FAIL gapped_ready: got %0d pulses lat=%0d required 1 and 1", obs_cnt, obs_lat);
        end
        tests_run++;
        if (obs_dout !== 16'd14) begin
            tests_failed++;
            $display("FAIL gapped_dout: got %h required %h", obs_dout, 16'd14);
        end
    endtask

    task automatic test_size_zero();
        elem_q.delete();
        gap_q.delete();
        run_vector(16'd0, 1'b0, 1'b1);
        tests_run++;
        if (obs_state_last !== 2'd2) begin
            tests_failed++;
            $display("FAIL size0_state: got %0d required 2", obs_state_last);
        end
        tests_run++;
        if (obs_lat !== 1 || obs_cnt !== 1 || obs_dout !== 16'd0) begin
            tests_failed++;
            $display("FAIL size0_result: got lat=%0d pulses=%0d dout=%h required 1 1 0000", obs_lat, obs_cnt, obs_dout);
        end
    endtask

    task automatic test_back_to_back();
        int ready_ok;
        start   = 1'b1;
        size_in = 16'd2;
        @(posedge clk); #1;
        start   = 1'b0;
        die     = 1'b1;
        data_in = 16'd3;
        @(posedge clk); #1;
        data_in = 16'd4;
        @(posedge clk); #1;
        die = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if (ready !== 1'b1 || dout !== 16'd7) begin
            tests_failed++;
            $display("FAIL b2b_first: got ready=%b dout=%h required 1 0007", ready, dout);
        end
        // Start the next run while READY is still high
        start   = 1'b1;
        size_in = 16'd2;
        @(posedge clk); #1;
        start = 1'b0;
        tests_run++;
        if (ready !== 1'b0 || state_dbg !== 2'd1) begin
            tests_failed++;
            $display("FAIL b2b_accept: got ready=%b st=%0d required 0 1", ready, state_dbg);
        end
        die     = 1'b1;
        data_in = 16'hFFFB;
        @(posedge clk); #1;
        data_in = 16'h0010;
        @(posedge clk); #1;
        die = 1'b0;
        ready_ok = 0;
        @(posedge clk); #1;
        if (ready === 1'b1) ready_ok = 1;
        tests_run++;
        if (ready_ok != 1 || dout !== 16'd11) begin
            tests_failed++;
            $display("FAIL b2b_second: got ready=%b dout=%h required 1 000b", ready, dout);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_run();
        int pulses;
        start   = 1'b1;
        size_in = 16'd4;
        @(posedge clk); #1;
        start   = 1'b0;
        die     = 1'b1;
        data_in = 16'd100;
        @(posedge clk); #1;
        data_in = 16'd200;
        @(posedge clk); #1;
        // Reset coincides with a strobe and START; reset must win
        rst     = 1'b1;
        data_in = 16'd300;
        start   = 1'b1;
        @(posedge clk); #1;
        rst   = 1'b0;
        die   = 1'b0;
        start = 1'b0;
        tests_run++;
        if ({ready, doe, ovf, dout, state_dbg} !== {3'b000, 16'h0000, 2'd0}) begin
            tests_failed++;
            $display("FAIL rst_mid_outputs: got ready=%b doe=%b ovf=%b dout=%h st=%0d required all 0",
                     ready, doe, ovf, dout, state_dbg);
        end
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            die     = 1'b1;
            data_in = W'($urandom);
            @(posedge clk); #1;
            if (ready !== 1'b0) pulses++;
        end
        die = 1'b0;
        tests_run++;
        if (pulses != 0) begin
            tests_failed++;
            $display("FAIL rst_mid_no_ready: got %0d pulses required 0", pulses);
        end
        elem_q = '{16'd1, 16'd1};
        gap_q  = '{0, 0};
        run_vector(16'd2, 1'b0, 1'b0);
        tests_run++;
        if (obs_dout !== 16'd2 || obs_lat !== 1) begin
            tests_failed++;
            $display("FAIL rst_mid_followup: got dout=%h lat=%0d required 0002 1", obs_dout, obs_lat);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] exp_sum;
        logic         exp_ovf;
        int           n;
        for (int r = 0; r < 25; r++) begin
            n = $urandom_range(0, 6);
            elem_q.delete();
            gap_q.delete();
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 1) == 1) elem_q.push_back(W'($urandom));
                else elem_q.push_back(W'($urandom_range(0, 40) - 20));
                gap_q.push_back($urandom_range(0, 2));
            end
            model_sum(exp_sum, exp_ovf);
            run_vector(W'(n), 1'($urandom_range(0, 1)), 1'b0);
            tests_run++;
            if (obs_lat !== 1 || obs_cnt !== 1) begin
                tests_failed++;
                $display("FAIL rand%0d_timing: got lat=%0d pulses=%0d required 1 1", r, obs_lat, obs_cnt);
            end
            tests_run++;
            if (obs_dout !== exp_sum) begin
                tests_failed++;
                $display("FAIL rand%0d_dout: got %h required %h (n=%0d)", r, obs_dout, exp_sum, n);
            end
            tests_run++;
            if (obs_ovf !== exp_ovf) begin
                tests_failed++;
                $display("FAIL rand%0d_overflow: got %b required %b", r, obs_ovf, exp_ovf);
            end
            tests_run++;
            if (obs_doe_ok !== 1'b1) begin
                tests_failed++;
                $display("FAIL rand%0d_doe: got DATA_OUT_ENABLE differing from READY required equal", r);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_pos_saturation();
        test_neg_saturation();
        test_gapped_ignored();
        test_size_zero();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
